// File: rtl/datapath.sv
// datapath -- small signed ALU followed by an optional output pipeline.
//
// The result {Y, co} is computed combinationally from A, B and opcode and is
// then delayed through `pipe` register stages. With pipe = 0 the outputs are
// purely combinational, and clk/rst have no effect.
//
// Optional feature: define DATAPATH_SAT_EN to clamp ADD/SUB results to the
// signed range on overflow. co always reports the raw unsigned carry.
//
// Parameters:
//   N     data width, 4..64
//   pipe  number of output register stages, 0..8
// Ports:
//   clk     rising-edge clock for the pipeline registers
//   rst     asynchronous active-high reset; clears every stage
//   A, B    signed two's-complement operands
//   opcode  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 ASR, 111 PASS
//   Y       result
//   co      carry (ADD/SUB), shifted-out bit (SHL/ASR), otherwise 0
module datapath #(
  parameter int N    = 16,
  parameter int pipe = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   opcode,
  output logic [N-1:0] Y,
  output logic         co
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  op_e          op;
  logic         is_sub;
  logic [N-1:0] b_op;
  logic [N:0]   sum;
  logic [N-1:0] y_c;
  logic         co_c;

  assign op     = op_e'(opcode);
  assign is_sub = (op == OP_SUB);

  // SUB reuses the adder as A + ~B + 1, so sum[N] is the "no borrow" carry.
  assign b_op = is_sub ? ~B : B;
  assign sum  = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, is_sub};

`ifdef DATAPATH_SAT_EN
  // Signed overflow: both adder inputs share a sign the result does not.
  logic         ovf;
  logic [N-1:0] clamp;
  assign ovf   = (A[N-1] == b_op[N-1]) && (sum[N-1] != A[N-1]);
  assign clamp = A[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif

  always_comb begin
    y_c  = '0;
    co_c = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        y_c  = sum[N-1:0];
        co_c = sum[N];
`ifdef DATAPATH_SAT_EN
        if (ovf) y_c = clamp;
`endif
      end
      OP_AND:  y_c = A & B;
      OP_OR:   y_c = A | B;
      OP_XOR:  y_c = A ^ B;
      OP_SHL: begin
        y_c  = {A[N-2:0], 1'b0};
        co_c = A[N-1];
      end
      OP_ASR: begin
        y_c  = {A[N-1], A[N-1:1]};
        co_c = A[0];
      end
      OP_PASS: y_c = A;
      default: ;
    endcase
  end

  generate
    if (pipe == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign Y  = y_c;
      assign co = co_c;
    end else begin : g_pipe
      // stg[0] is loaded first; stg[pipe-1] drives the outputs.
      logic [pipe-1:0][N:0] stg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg <= '0;
        end else begin
          stg[0] <= {co_c, y_c};
          for (int i = 1; i < pipe; i++) stg[i] <= stg[i-1];
        end
      end

      assign {co, Y} = stg[pipe-1];
    end
  endgenerate

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: three instances (pipe = 0, 1, 3) share the
// same stimulus. Each issued vector pushes its expected {Y, co} with the edge
// on which it must emerge; per-instance monitors pop and compare.
module tb_datapath;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [2:0]   opcode = '0;
  logic [N-1:0] y0, y1, y3;
  logic         co0, co1, co3;

  datapath #(.N(N), .pipe(0)) dut0 (.clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .Y(y0), .co(co0));
  datapath #(.N(N), .pipe(1)) dut1 (.clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .Y(y1), .co(co1));
  datapath #(.N(N), .pipe(3)) dut3 (.clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .Y(y3), .co(co3));

  always #5 clk = ~clk;

  typedef struct packed { logic co; logic [N-1:0] y; } res_t;
  typedef struct { int stamp; logic [N-1:0] y; logic co; string nm; } exp_t;
  typedef struct { logic [N-1:0] a, b; logic [2:0] op; logic [N-1:0] y; logic co; string nm; } vec_t;

  exp_t q1[$], q3[$];
  vec_t dir[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    int ua, ub, sa, sb, s;
    res_t r;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    s = 0;
    r = '0;
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0) begin
          r.co = (ua + ub) >= (1 << N);
          s = sa + sb;
        end else begin
          r.co = (ua >= ub);
          s = sa - sb;
        end
        r.y = N'(s);
`ifdef DATAPATH_SAT_EN
        if (s > (1 << (N-1)) - 1) r.y = N'((1 << (N-1)) - 1);
        else if (s < -(1 << (N-1))) r.y = N'(-(1 << (N-1)));
`endif
      end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: begin r.y = N'(ua * 2); r.co = (ua >= (1 << (N-1))); end
      3'd6: begin r.y = N'((sa - (ua % 2)) / 2); r.co = (ua % 2) == 1; end
      default: r.y = a;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] gy, input logic gc,
                     input logic [N-1:0] ey, input logic ec);
    checks++;
    if (gy !== ey || gc !== ec) begin
      errors++;
      $display("FAIL %s: got Y=%h co=%b, expected Y=%h co=%b", nm, gy, gc, ey, ec);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                       input logic [N-1:0] ey, input logic ec, input string nm);
    A = a; B = b; opcode = op;
    if (!rst) begin
      q1.push_back('{cyc + 1, ey, ec, {nm, "/p1"}});
      q3.push_back('{cyc + 3, ey, ec, {nm, "/p3"}});
    end
    #1 chk({nm, "/p0"}, y0, co0, ey, ec);
    @(negedge clk);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    while (q1.size() > 0 && q1[0].stamp <= cyc) begin
      e = q1.pop_front();
      chk(e.nm, y1, co1, e.y, e.co);
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    while (q3.size() > 0 && q3[0].stamp <= cyc) begin
      e = q3.pop_front();
      chk(e.nm, y3, co3, e.y, e.co);
    end
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic [2:0]   rop;
    res_t         m;

    dir.push_back('{16'd100,  16'd200,  3'd0, 16'd300,  1'b0, "add_100_200"});
    dir.push_back('{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, "add_m1_1"});
    dir.push_back('{16'd5,    16'd7,    3'd1, 16'hFFFE, 1'b0, "sub_5_7"});
    dir.push_back('{16'd7,    16'd5,    3'd1, 16'h0002, 1'b1, "sub_7_5"});
`ifdef DATAPATH_SAT_EN
    dir.push_back('{16'h7FFF, 16'h0001, 3'd0, 16'h7FFF, 1'b0, "add_pos_ovf"});
    dir.push_back('{16'h8000, 16'hFFFF, 3'd0, 16'h8000, 1'b1, "add_neg_ovf"});
    dir.push_back('{16'h8000, 16'h0001, 3'd1, 16'h8000, 1'b1, "sub_neg_ovf"});
`else
    dir.push_back('{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0, "add_pos_ovf"});
    dir.push_back('{16'h8000, 16'hFFFF, 3'd0, 16'h7FFF, 1'b1, "add_neg_ovf"});
    dir.push_back('{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1'b1, "sub_neg_ovf"});
`endif
    dir.push_back('{16'h8001, 16'h1234, 3'd5, 16'h0002, 1'b1, "shl_8001"});
    dir.push_back('{16'hFFFD, 16'h0000, 3'd6, 16'hFFFE, 1'b1, "asr_m3"});
    dir.push_back('{16'hA5A5, 16'h0FF0, 3'd2, 16'h05A0, 1'b0, "and"});
    dir.push_back('{16'h1200, 16'h0034, 3'd3, 16'h1234, 1'b0, "or"});
    dir.push_back('{16'hA5A5, 16'h0FF0, 3'd4, 16'hAA55, 1'b0, "xor"});
    dir.push_back('{16'h1234, 16'hFFFF, 3'd7, 16'h1234, 1'b0, "pass"});
    dir.push_back('{16'd1,    16'd2,    3'd0, 16'd3,    1'b0, "seq_add"});
    dir.push_back('{16'd9,    16'd4,    3'd1, 16'd5,    1'b1, "seq_sub"});
    dir.push_back('{16'd6,    16'd3,    3'd2, 16'd2,    1'b0, "seq_and"});

    // Power-on reset with live inputs: registered outputs must read 0.
    A = 16'h1234; B = 16'h4321; opcode = 3'd0;
    #1;
    chk("rst_init/p1", y1, co1, '0, 1'b0);
    chk("rst_init/p3", y3, co3, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold/p1", y1, co1, '0, 1'b0);
    chk("rst_hold/p3", y3, co3, '0, 1'b0);
    chk("rst_hold/p0", y0, co0, 16'h5555, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) issue(dir[i].a, dir[i].b, dir[i].op, dir[i].y, dir[i].co, dir[i].nm);

    for (int i = 0; i < 300; i++) begin
      ra = N'($urandom); rb = N'($urandom); rop = 3'($urandom);
      if (i % 7 == 0) ra = 16'h7FFF;
      if (i % 11 == 0) rb = 16'h8000;
      m = model(ra, rb, rop);
      issue(ra, rb, rop, m.y, m.co, "rand");
    end

    // Mid-cycle reset pulse: in-flight results are discarded.
    #2;
    rst = 1'b1;
    q1.delete(); q3.delete();
    A = 16'h0F0F; B = 16'h00F1; opcode = 3'd1;
    #1;
    chk("rst_async/p1", y1, co1, '0, 1'b0);
    chk("rst_async/p3", y3, co3, '0, 1'b0);
    m = model(A, B, opcode);
    chk("rst_async/p0", y0, co0, m.y, m.co);
    @(posedge clk);
    #1;
    chk("rst_mid_hold/p1", y1, co1, '0, 1'b0);
    chk("rst_mid_hold/p3", y3, co3, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Stage 3 has not refilled on the first two edges after release.
    fork
      begin
        @(posedge clk); #1 chk("post_rst_e1/p3", y3, co3, '0, 1'b0);
        @(posedge clk); #1 chk("post_rst_e2/p3", y3, co3, '0, 1'b0);
      end
    join_none
    issue(16'd1, 16'd2, 3'd0, 16'd3, 1'b0, "post_rst_add");
    issue(16'd9, 16'd4, 3'd1, 16'd5, 1'b1, "post_rst_sub");
    issue(16'd6, 16'd3, 3'd2, 16'd2, 1'b0, "post_rst_and");

    for (int i = 0; i < 20 && (q1.size() > 0 || q3.size() > 0); i++) @(posedge clk);
    #2;
    checks++;
    if (q1.size() > 0 || q3.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d results never emerged, expected 0/0", q1.size(), q3.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter N, default 16, data width in bits; legal range 4..64.
REQ-002 Parameter pipe, default 1, number of output pipeline register stages; legal range 0..8.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all pipeline registers.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 A  input  N  signed operand A, two's complement.
REQ-007 B  input  N  signed operand B, two's complement.
REQ-008 opcode  input  3  operation select.
REQ-009 Y  output  N  signed result.
REQ-010 co  output  1  carry or shift-out flag.

Function
REQ-011 The block SHALL use this opcode map:
- 000 ADD: Y = A+B; co = bit N of the unsigned (N+1)-bit sum.
- 001 SUB: Y = A-B, computed as A+~B+1; co = carry out, where 1 means no borrow.
- 010 AND: Y = A&B; co = 0.
- 011 OR: Y = A|B; co = 0.
- 100 XOR: Y = A^B; co = 0.
- 101 SHL: Y = A<<1 with zero fill; co = A[N-1].
- 110 ASR: Y = A>>>1 with sign fill; co = A[0].
- 111 PASS: Y = A; co = 0.
REQ-012 The result SHALL be computed combinationally from A, B and opcode, then delayed through pipe register stages.
- Each stage holds {Y, co}.
- All stages load on every rising clk edge; there is no enable and no stall.
REQ-013 When pipe = 0, Y and co SHALL be purely combinational, with zero latency and no registers.
REQ-014 When pipe = k >= 1, latency SHALL be exactly k rising edges.
- An input set applied before edge n appears on Y/co after edge n+k-1.
- Back-to-back input sets SHALL emerge in order, one per cycle.
REQ-015 Without saturation, ADD and SUB SHALL wrap modulo 2^N.
REQ-016 co SHALL be independent of signed overflow.
- Example: 0x7FFF+0x0001 with N=16 gives co=0.

Reset
REQ-017 Asserting rst SHALL immediately clear every pipeline stage, so Y=0 and co=0 without waiting for a clock edge.
REQ-018 While rst is high, Y and co SHALL remain 0 regardless of clk or inputs.
REQ-019 After rst deasserts, the first edge SHALL load stage 1 normally, and valid data SHALL reach Y after pipe edges.
- Stages not yet refilled SHALL output 0.
REQ-020 For pipe = 0, rst SHALL have no effect on Y or co.

Configuration
REQ-021 Macro DATAPATH_SAT_EN, when defined, SHALL enable signed saturation for ADD and SUB.
- On signed overflow, Y SHALL clamp to 2^(N-1)-1 (positive overflow) or -2^(N-1) (negative overflow).
- co SHALL be unaffected.
REQ-022 When DATAPATH_SAT_EN is undefined, ADD and SUB SHALL wrap per REQ-015, and no saturation logic SHALL be present.

Verification
REQ-023 Bench SHALL cover (N=16, pipe=1 unless stated):
- ADD, A=100, B=200 -> one edge later Y=300, co=0.
- ADD, A=-1, B=1 -> Y=0, co=1.
- SUB, A=5, B=7 -> Y=-2, co=0.
- SUB, A=7, B=5 -> Y=2, co=1.
- ADD, A=32767, B=1 -> Y=-32768, co=0 without DATAPATH_SAT_EN; Y=32767, co=0 with it.
- SHL, A=0x8001 -> Y=0x0002, co=1.
- ASR, A=-3 -> Y=-2, co=1.
- pipe=3: inputs (1,2,ADD), (9,4,SUB), (6,3,AND) on consecutive edges -> Y = 3, 5, 2 on edges 3, 4, 5.
- rst pulse mid-stream between edges -> Y=0, co=0 immediately.
- After rst release: Y=0 until the first post-reset result emerges after pipe edges.
